// File: rtl/dm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : dm_arbiter_if
// Brief   : Master request/response and data-memory bundle of dm_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
interface dm_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [3:0]  m0_be;
  logic [11:2] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ack;

  logic        m1_req;
  logic        m1_we;
  logic [3:0]  m1_be;
  logic [11:2] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ack;

  logic [11:2] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
           m1_req, m1_we, m1_be, m1_addr, m1_wdata, mem_dout,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
           mem_addr, mem_din, mem_read, mem_write
  );

  // Requesters plus the memory array.
  modport master (
    output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
           m1_req, m1_we, m1_be, m1_addr, m1_wdata, mem_dout,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
           mem_addr, mem_din, mem_read, mem_write
  );
endinterface
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dm_arbiter
// Brief   : Round-robin two-master sequencer for a 1Kx32 single-port memory,
//           with read-modify-write for partial-word writes.
// Rev     : 1.0  initial release
// ============================================================================
module dm_arbiter (
  input  wire          clk,
  input  wire          rst,
  dm_arbiter_if.slave  bus,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC    = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] C_BE_FULL = 4'hF;
  localparam logic [3:0] C_BE_NONE = 4'h0;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [11:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        w_any_req;
  logic        w_grant;
  logic        w_sel_we;
  logic [3:0]  w_sel_be;
  logic [11:2] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [31:0] w_be_mask;
  logic        w_mem_read;
  logic        w_mem_write;
  logic [11:2] w_mem_addr;
  logic [31:0] w_mem_din;
  logic        w_ack0;
  logic        w_ack1;

  // Contention goes to whichever master did not win last time.
  assign w_any_req   = bus.m0_req | bus.m1_req;
  assign w_grant     = (bus.m0_req & bus.m1_req) ? ~last_owner_q : bus.m1_req;
  assign w_sel_we    = w_grant ? bus.m1_we    : bus.m0_we;
  assign w_sel_be    = w_grant ? bus.m1_be    : bus.m0_be;
  assign w_sel_addr  = w_grant ? bus.m1_addr  : bus.m0_addr;
  assign w_sel_wdata = w_grant ? bus.m1_wdata : bus.m0_wdata;

  for (genvar i = 0; i < 4; i++) begin : g_be_mask
    assign w_be_mask[8*i +: 8] = {8{be_q[i]}};
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merged_d     = merged_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_addr   = '0;
    w_mem_din    = '0;
    w_ack0       = 1'b0;
    w_ack1       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_any_req) begin
          owner_d      = w_grant;
          last_owner_d = w_grant;
          we_d         = w_sel_we;
          be_d         = w_sel_be;
          addr_d       = w_sel_addr;
          wdata_d      = w_sel_wdata;
          if (!w_sel_we || w_sel_be == C_BE_FULL || w_sel_be == C_BE_NONE) begin
            state_d = S_ACC;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_ACC: begin
        w_mem_addr = addr_q;
        if (!we_q) begin
          w_mem_read = 1'b1;
          if (owner_q) m1_rdata_d = bus.mem_dout;
          else         m0_rdata_d = bus.mem_dout;
        end else if (be_q == C_BE_FULL) begin
          w_mem_write = 1'b1;
          w_mem_din   = wdata_q;
        end
        state_d = S_DONE;
      end
      S_RMW_RD: begin
        w_mem_addr = addr_q;
        w_mem_read = 1'b1;
        merged_d   = (wdata_q & w_be_mask) | (bus.mem_dout & ~w_be_mask);
        state_d    = S_RMW_WR;
      end
      S_RMW_WR: begin
        w_mem_addr  = addr_q;
        w_mem_write = 1'b1;
        w_mem_din   = merged_q;
        state_d     = S_DONE;
      end
      S_DONE: begin
        w_ack0  = ~owner_q;
        w_ack1  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      merged_q     <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merged_q     <= merged_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Reset kills strobes and acks in the same cycle so an aborted access never lands.
  assign bus.mem_write = w_mem_write & ~rst;
  assign bus.mem_read  = w_mem_read  & ~rst;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_din   = w_mem_din;
  assign bus.m0_ack    = w_ack0 & ~rst;
  assign bus.m1_ack    = w_ack1 & ~rst;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dm_arbiter
// Brief   : Randomized bench for dm_arbiter with a transaction-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dm_arbiter;

  typedef struct packed {
    logic        a0, a1, rd, wr, acc, bsy, upd, port;
    logic [9:0]  addr;
    logic [31:0] din;
    logic [31:0] rval;
  } cyc_t;

  typedef struct { int c; int p; } ack_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  dm_arbiter_if bus ();

  dm_arbiter u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory array seen by the DUT: combinational read, write on the edge.
  logic [31:0] tb_mem [1024];
  assign bus.mem_dout = tb_mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_write) tb_mem[bus.mem_addr] <= bus.mem_din;

  // Reference state.
  logic [31:0] ref_mem [1024];
  cyc_t        q[$];
  cyc_t        cur = '0;
  cyc_t        idle_rec = '0;
  logic        last_m = 1'b1;
  logic [31:0] exp_rd [2];
  bit          model_live = 1'b0;

  // Event logs filled by the compare process.
  int          wr_cnt = 0, wr_cyc = -1, rd_cyc = -1, ack_cnt = 0;
  logic [31:0] wr_din = '0;
  ack_t        ack_log[$];
  bit          rand_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: each grant expands into the per-cycle output sequence it must produce.
  initial begin
    cyc_t        r;
    logic        g, we;
    logic [3:0]  be;
    logic [9:0]  a;
    logic [31:0] wd, m;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    forever begin
      @(posedge clk);
      model_live = 1'b1;
      if (!rst && cur.wr) ref_mem[cur.addr] = cur.din;
      if (rst) begin
        q.delete();
        cur       = idle_rec;
        last_m    = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
      end else begin
        if (q.size() == 0 && (bus.m0_req || bus.m1_req)) begin
          g      = (bus.m0_req && bus.m1_req) ? !last_m : bus.m1_req;
          last_m = g;
          we = g ? bus.m1_we    : bus.m0_we;
          be = g ? bus.m1_be    : bus.m0_be;
          a  = g ? bus.m1_addr  : bus.m0_addr;
          wd = g ? bus.m1_wdata : bus.m0_wdata;
          r = '0; r.bsy = 1'b1; r.acc = 1'b1; r.addr = a;
          if (!we) begin
            r.rd = 1'b1; q.push_back(r);
          end else if (be == 4'hF) begin
            r.wr = 1'b1; r.din = wd; q.push_back(r);
          end else if (be == 4'h0) begin
            q.push_back(r);
          end else begin
            m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            r.rd = 1'b1; q.push_back(r);
            r.rd = 1'b0; r.wr = 1'b1; r.din = (wd & m) | (ref_mem[a] & ~m);
            q.push_back(r);
          end
          r = '0; r.bsy = 1'b1;
          if (g) r.a1 = 1'b1; else r.a0 = 1'b1;
          if (!we) begin r.upd = 1'b1; r.port = g; r.rval = ref_mem[a]; end
          q.push_back(r);
          q.push_back(idle_rec);
        end
        cur = (q.size() > 0) ? q.pop_front() : idle_rec;
        if (cur.upd) exp_rd[cur.port] = cur.rval;
      end
    end
  end

  // Compare process, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        check("m0_ack",    32'(bus.m0_ack),    32'(cur.a0 && !rst));
        check("m1_ack",    32'(bus.m1_ack),    32'(cur.a1 && !rst));
        check("mem_read",  32'(bus.mem_read),  32'(cur.rd && !rst));
        check("mem_write", 32'(bus.mem_write), 32'(cur.wr && !rst));
        check("busy",      32'(busy),          32'(cur.bsy));
        check("mem_addr",  32'(bus.mem_addr),  32'(cur.addr));
        if (cur.wr || !cur.acc) check("mem_din", bus.mem_din, cur.din);
        check("m0_rdata",  bus.m0_rdata, exp_rd[0]);
        check("m1_rdata",  bus.m1_rdata, exp_rd[1]);
        if (bus.mem_write) begin wr_cnt++; wr_cyc = cyc; wr_din = bus.mem_din; end
        if (bus.mem_read) rd_cyc = cyc;
        if (bus.m0_ack) begin ack_cnt++; ack_log.push_back('{cyc, 0}); end
        if (bus.m1_ack) begin ack_cnt++; ack_log.push_back('{cyc, 1}); end
      end
    end
  end

  // Called one step after a rising edge in an IDLE cycle; returns one step after
  // the edge that ends the ack cycle.
  task automatic do_txn(input int p, input logic we, input logic [3:0] be,
                        input logic [9:0] addr, input logic [31:0] wd,
                        output int lat, output int k0, output logic [31:0] rd);
    bit got = 1'b0;
    lat = -1;
    rd  = '0;
    if (p == 0) begin
      bus.m0_we = we; bus.m0_be = be; bus.m0_addr = addr; bus.m0_wdata = wd; bus.m0_req = 1'b1;
    end else begin
      bus.m1_we = we; bus.m1_be = be; bus.m1_addr = addr; bus.m1_wdata = wd; bus.m1_req = 1'b1;
    end
    k0 = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? bus.m0_ack : bus.m1_ack) begin
        got = 1'b1;
        lat = cyc - k0;
        rd  = (p == 0) ? bus.m0_rdata : bus.m1_rdata;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout port %0d: got no ack, expected ack within 40 cycles", p);
    end
    @(posedge clk); #1;
    if (p == 0) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
  endtask

  task automatic rand_master(input int p, input int n);
    int          lat, k0, gap;
    logic [31:0] rdv;
    logic        we;
    logic [3:0]  be;
    for (int t = 0; t < n; t++) begin
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3));
      repeat (gap) begin @(posedge clk); #1; end
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       be = 4'hF;
        1:       be = 4'h0;
        default: be = 4'($urandom);
      endcase
      do_txn(p, we, be, 10'($urandom_range(0, 15)), $urandom, lat, k0, rdv);
    end
  endtask

  task automatic rand_rst();
    while (rand_on) begin
      @(posedge clk); #1;
      rst = rand_on && ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat, k0, wr0, a0, lat0, lat1, k00, k01;
    logic [31:0] rdv, rdv0, rdv1;

    for (int i = 0; i < 1024; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end

    // Reset held two cycles with random request traffic.
    rst = 1'b1;
    bus.m0_req = 1'b1; bus.m0_we = 1'($urandom); bus.m0_be = 4'($urandom);
    bus.m0_addr = 10'($urandom); bus.m0_wdata = $urandom;
    bus.m1_req = 1'b1; bus.m1_we = 1'($urandom); bus.m1_be = 4'($urandom);
    bus.m1_addr = 10'($urandom); bus.m1_wdata = $urandom;
    repeat (2) begin
      @(negedge clk);
      check("rst_acks",   32'({bus.m0_ack, bus.m1_ack}), 32'd0);
      check("rst_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd0);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_rdata",  bus.m0_rdata | bus.m1_rdata, 32'd0);
      check("rst_bus",    32'(bus.mem_addr) | bus.mem_din, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    @(posedge clk); #1;

    // Full write, then read back.
    wr0 = wr_cnt;
    do_txn(0, 1'b1, 4'hF, 10'h004, 32'hDEADBEEF, lat, k0, rdv);
    check("fw_latency",  32'(lat), 32'd2);
    check("fw_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("fw_wr_cycle", 32'(wr_cyc - k0), 32'd1);
    do_txn(0, 1'b0, 4'h0, 10'h004, 32'h0, lat, k0, rdv);
    check("rd_latency", 32'(lat), 32'd2);
    check("rd_data",    rdv, 32'hDEADBEEF);

    // Partial write by m1 merges into the stored word.
    wr0 = wr_cnt;
    do_txn(1, 1'b1, 4'b0010, 10'h004, 32'h0000AB00, lat, k0, rdv);
    check("pw_latency",  32'(lat), 32'd3);
    check("pw_rd_cycle", 32'(rd_cyc - k0), 32'd1);
    check("pw_wr_cycle", 32'(wr_cyc - k0), 32'd2);
    check("pw_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("pw_din",      wr_din, 32'hDEADABEF);
    do_txn(1, 1'b0, 4'hF, 10'h004, 32'h0, lat, k0, rdv);
    check("pw_readback", rdv, 32'hDEADABEF);

    // Empty write touches nothing.
    wr0 = wr_cnt;
    do_txn(0, 1'b1, 4'h0, 10'h004, 32'h12345678, lat, k0, rdv);
    check("ew_latency",  32'(lat), 32'd2);
    check("ew_wr_count", 32'(wr_cnt - wr0), 32'd0);
    do_txn(0, 1'b0, 4'h0, 10'h004, 32'h0, lat, k0, rdv);
    check("ew_readback", rdv, 32'hDEADABEF);

    // Reset during the write half of a read-modify-write.
    wr0 = wr_cnt; a0 = ack_cnt;
    bus.m0_we = 1'b1; bus.m0_be = 4'b0001; bus.m0_addr = 10'h004;
    bus.m0_wdata = 32'h000000FF; bus.m0_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_write", 32'(bus.mem_write), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.m0_req = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_ack",   32'(ack_cnt - a0), 32'd0);
    check("mid_rst_wrcnt", 32'(wr_cnt - wr0), 32'd0);
    check("mid_rst_mem",   tb_mem[4], 32'hDEADABEF);
    @(posedge clk); #1;

    // Both masters requesting from reset: strict alternation.
    rst = 1'b1;
    ack_log.delete();
    fork
      begin @(posedge clk); #1; rst = 1'b0; end
      begin
        do_txn(0, 1'b1, 4'hF, 10'h020, 32'h11111111, lat0, k00, rdv0);
        do_txn(0, 1'b1, 4'hF, 10'h022, 32'h33333333, lat0, k00, rdv0);
      end
      begin
        do_txn(1, 1'b1, 4'hF, 10'h021, 32'h22222222, lat1, k01, rdv1);
        do_txn(1, 1'b1, 4'hF, 10'h023, 32'h44444444, lat1, k01, rdv1);
      end
    join
    check("arb_ack_count", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("arb_order", 32'(ack_log[i].p), 32'(i % 2));
        if (i > 0) check("arb_spacing", 32'(ack_log[i].c - ack_log[i-1].c), 32'd3);
      end
    end
    check("arb_mem20", tb_mem[32], 32'h11111111);
    check("arb_mem23", tb_mem[35], 32'h44444444);

    // Random traffic with occasional resets.
    rand_on = 1'b1;
    fork
      rand_rst();
    join_none
    fork
      rand_master(0, 150);
      rand_master(1, 150);
    join
    rand_on = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) check("mem_final", tb_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer in front of the single-port 1K×32 data memory (word address [11:2], `MemRead`/`MemWrite` strobes, write on clock edge, read combinational). It shares the memory between the CPU load/store path (port 0) and a secondary master such as a debug/DMA port (port 1) using round-robin arbitration with a req/ack handshake. It also turns partial-word (byte-enable) writes into a read-modify-write sequence, because the memory supports only full-word writes.

## Interface
- No parameters; memory geometry is fixed at 1024 words × 32 bits.
- `clk` — input, 1 — single clock; all state updates on its rising edge.
- `rst` — input, 1 — synchronous, active-high reset.
- `m0_req`, `m1_req` — input, 1 — transfer request; hold high with fields stable until ack.
- `m0_we`, `m1_we` — input, 1 — 1 = write, 0 = read.
- `m0_be`, `m1_be` — input, 4 — byte enables for writes; bit i covers data[8i+7:8i]; ignored on reads.
- `m0_addr`, `m1_addr` — input, [11:2] — word address.
- `m0_wdata`, `m1_wdata` — input, 32 — write data.
- `m0_rdata`, `m1_rdata` — output, 32 — registered read data; valid in the ack cycle.
- `m0_ack`, `m1_ack` — output, 1 — one-cycle completion pulse.
- `mem_addr` — output, [11:2] — drives the memory address.
- `mem_din` — output, 32 — drives the memory write data.
- `mem_read`, `mem_write` — output, 1 — drive the memory `MemRead`/`MemWrite` strobes.
- `mem_dout` — input, 32 — memory read data.
- `busy` — output, 1 — high in any state other than IDLE.

## Operation
- **States:** IDLE, ACC, RMW_RD, RMW_WR, DONE.
- **IDLE, arbitration:**
  - Only one master requesting: it wins.
  - Both requesting: the master that did not win last time wins (`last_owner` register; reset value 1, so port 0 wins first).
  - On the clock edge, latch `owner`, `addr`, `we`, `be`, `wdata`, and update `last_owner`.
- **IDLE, next state:**
  - Read, full write (`be`=4'hF), or empty write (`be`=4'h0): go to ACC.
  - Any other write: go to RMW_RD.
- **ACC:**
  - `mem_addr` = latched addr.
  - Read: `mem_read`=1, and `rdata_q` <= `mem_dout` on the edge.
  - Full write: `mem_write`=1, `mem_din` = latched wdata.
  - `be`=0 write: no strobe.
  - Next state: DONE.
- **RMW_RD:** `mem_read`=1. On the edge, `merged` <= byte-merge of `mem_dout` and wdata (bytes with `be`[i]=1 come from wdata, others from `mem_dout`). Next state: RMW_WR.
- **RMW_WR:** `mem_write`=1, `mem_din` = `merged`. Next state: DONE.
- **DONE:**
  - Owner's `mX_ack`=1 for exactly this cycle; `mX_rdata` = `rdata_q` (reads only; unchanged otherwise).
  - `req` is ignored in this cycle.
  - Next state: IDLE.
- **Back-to-back requests:** a master that keeps `req` high after ack has issued a new request, arbitrated in the following IDLE cycle with whatever fields are then present.
- **Outside ACC/RMW_RD/RMW_WR:** `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_din`=0.
- **Write gating:** `mem_write` is gated with `!rst`, so a reset asserted during ACC or RMW_WR suppresses the write.
- **Reset:**
  - State → IDLE, `last_owner`=1.
  - Both acks 0; `rdata_q`, `merged`, and all latched fields 0.
  - `busy`=0.
  - An aborted transfer produces no ack. The master sees its req unacknowledged and re-arbitrates after reset.

## Timing
- Cycle T0: IDLE samples `req`.
- Read or full/empty write:
  - T1: ACC.
  - T2: DONE, ack.
  - Latency 2 cycles from the sampling edge; one transfer every 3 cycles.
- Partial write:
  - T1: RMW_RD.
  - T2: RMW_WR; memory is updated at the end of T2.
  - T3: DONE, ack.
  - Latency 3 cycles.
- **Fairness:** with both masters continuously requesting, grants strictly alternate, giving maximum wait of one foreign transfer (≤4 cycles).
- **No overlap:** acks are never simultaneous, and at most one of `mem_read`/`mem_write` is high in any cycle.

## Test plan
- **Reset:** hold `rst` 2 cycles with random inputs. Require all outputs 0, `busy`=0, and no memory strobe.
- **Full write then read:** m0 writes addr 10'h004, data 32'hDEADBEEF, `be`=4'hF. Require `m0_ack` at T2 and one `mem_write` pulse at T1. Then m0 reads 10'h004; require `m0_rdata`=32'hDEADBEEF with ack at T2.
- **Partial write:** m1 writes `be`=4'b0010, data 32'h0000AB00 to 10'h004 (holding DEADBEEF). Require `mem_read` at T1, `mem_write` at T2 with `mem_din`=32'hDEADABEF, `m1_ack` at T3. A later read returns DEADABEF.
- **Simultaneous requests:** both `req` high from reset, each a full write to a distinct address. Require grant order m0, m1, m0, m1 and acks 3 cycles apart.
- **Empty write:** `be`=4'h0 write. Require ack at T2, `mem_write` never asserted, and memory unchanged.
- **Reset mid-operation:** assert `rst` during RMW_WR of a partial write. Require `mem_write` low that cycle, target word unchanged, no ack, and `busy`=0 next cycle.
